cla_multiword_seq: RTL and testbench

- Sequential wide adder that computes A + B + Cin on WORDS*N-bit operands.
- It reuses one N-bit CLA #(N) instance (ports A, B, Cin, S, Cout), one word per clock, least significant word first.
- The carry between words is held in a register.
- It sits directly upstream of the existing N-bit CLA and feeds it word slices, so wide additions need no wider adder hardware.

---
 rtl/cla_multiword_seq.sv | 172 +++++++++++++++++
 tb/tb_cla_multiword_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cla_multiword_seq.sv
// Sequential wide adder: A + B + Cin on WORDS*N-bit operands through one N-bit CLA,
// one word per clock, least significant word first, with the inter-word carry held in a register.
module cla_multiword_seq #(
  parameter int unsigned N     = 16,
  parameter int unsigned WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N*WORDS-1:0]   a,
  input  logic [N*WORDS-1:0]   b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [N*WORDS-1:0]   sum,
  output logic                 cout
);

  localparam int unsigned W  = N * WORDS;
  localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [WORDS-1:0][N-1:0]   a_q, a_d;
  logic [WORDS-1:0][N-1:0]   b_q, b_d;
  logic [WORDS-1:0][N-1:0]   part_q, part_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic                      carry_q, carry_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      cout_q, cout_d;
  logic [W-1:0]              sum_q, sum_d;

  logic [N-1:0]              cla_a, cla_b, cla_s;
  logic                      cla_cout;

  // Current word slice of each operand feeds the shared CLA.
  assign cla_a = a_q[idx_q];
  assign cla_b = b_q[idx_q];

  cla #(.N(N)) u_cla (
    .A    (cla_a),
    .B    (cla_b),
    .Cin  (carry_q),
    .S    (cla_s),
    .Cout (cla_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      sum_q   <= sum_d;
    end
  end

  // Next-state and next-output logic; done defaults low so it only pulses.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cout_d  = cout_q;
    sum_d   = sum_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        part_d[idx_q] = cla_s;
        carry_d       = cla_cout;
        idx_d         = idx_q + IW'(1);
        if (idx_q == IW'(WORDS - 1)) begin
          // Completion edge publishes the full result, final slice included.
          sum_d   = W'(part_d);
          cout_d  = cla_cout;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// N-bit carry-lookahead adder built on a parallel-prefix (Kogge-Stone) generate/propagate tree.
module cla #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] S,
  output logic         Cout
);

  localparam int unsigned LV = (N > 1) ? $clog2(N) : 0;

  // Group generate/propagate over [i:0] via log2(N) prefix levels, then fold in Cin.
  function automatic logic [N:0] carries(input logic [N-1:0] g_in,
                                         input logic [N-1:0] p_in,
                                         input logic         ci);
    logic [N-1:0] g, p, gn, pn;
    logic [N:0]   c;
    g = g_in;
    p = p_in;
    for (int l = 0; l < int'(LV); l++) begin
      gn = g;
      pn = p;
      for (int i = (1 << l); i < int'(N); i++) begin
        gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
        pn[i] = p[i] & p[i - (1 << l)];
      end
      g = gn;
      p = pn;
    end
    c[0] = ci;
    for (int i = 0; i < int'(N); i++) begin
      c[i+1] = g[i] | (p[i] & ci);
    end
    return c;
  endfunction

  logic [N:0] c;

  assign c    = carries(A & B, A ^ B, Cin);
  assign S    = (A ^ B) ^ c[N-1:0];
  assign Cout = c[N];

endmodule

// File: tb/tb_cla_multiword_seq.sv
// Self-checking bench: a 4-word and a 1-word instance checked against plain wide arithmetic.
module tb_cla_multiword_seq;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        s4, c4, busy4, done4, cout4;
  logic [63:0] a4, b4, sum4;
  logic        s1, c1, busy1, done1, cout1;
  logic [15:0] a1, b1, sum1;

  int tests = 0;
  int fails = 0;
  logic [64:0] last4;

  always #5 clk = ~clk;

  cla_multiword_seq #(.N(16), .WORDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4), .cin(c4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  cla_multiword_seq #(.N(16), .WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .a(a1), .b(b1), .cin(c1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] ref64(input logic [63:0] x, input logic [63:0] y, input logic ci);
    return {1'b0, x} + {1'b0, y} + 65'(ci);
  endfunction

  function automatic logic [16:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic ci);
    return {1'b0, x} + {1'b0, y} + 17'(ci);
  endfunction

  // One full operation on the 4-word instance, checking timing, stability and result.
  task automatic op4(input string tag, input logic [63:0] x, input logic [63:0] y, input logic ci);
    logic [64:0] exp;
    exp = ref64(x, y, ci);
    @(negedge clk);
    a4 = x; b4 = y; c4 = ci; s4 = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".busy_start"}, 65'(busy4), 65'(1));
    @(negedge clk);
    s4 = 1'b0; a4 = ~x; b4 = ~y; c4 = ~ci;
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      chk({tag, ".run_busy_done"}, {63'(0), busy4, done4}, {63'(0), 1'b1, 1'b0});
      chk({tag, ".run_hold"}, {cout4, sum4}, last4);
    end
    @(posedge clk); #1;
    chk({tag, ".done"}, {63'(0), busy4, done4}, {63'(0), 1'b0, 1'b1});
    chk({tag, ".result"}, {cout4, sum4}, exp);
    last4 = exp;
    @(posedge clk); #1;
    chk({tag, ".done_clear"}, 65'(done4), 65'(0));
  endtask

  task automatic op1(input string tag, input logic [15:0] x, input logic [15:0] y, input logic ci);
    logic [16:0] exp;
    exp = ref16(x, y, ci);
    @(negedge clk);
    a1 = x; b1 = y; c1 = ci; s1 = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".busy"}, {63'(0), busy1, done1}, {63'(0), 1'b1, 1'b0});
    @(negedge clk);
    s1 = 1'b0; a1 = '0; b1 = '0;
    @(posedge clk); #1;
    chk({tag, ".done"}, {63'(0), busy1, done1}, {63'(0), 1'b0, 1'b1});
    chk({tag, ".result"}, 65'({cout1, sum1}), 65'(exp));
    @(posedge clk); #1;
    chk({tag, ".done_clear"}, 65'(done1), 65'(0));
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic        rc;
    logic [64:0] expq[$];
    logic [64:0] e;

    rst_n = 1'b0;
    s4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0;
    s1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
    last4 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset4", {busy4, done4, cout4, sum4[61:0]}, '0);
    chk("reset4_sum_hi", 65'(sum4[63:62]), 65'(0));
    chk("reset1", 65'({busy1, done1, cout1, sum1}), 65'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Basic, inter-word carry, overflow
    op4("t1", 64'd1, 64'd2, 1'b0);
    op4("t2a", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0);
    op4("t2b", 64'h0000_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    op4("t3a", '1, '1, 1'b0);
    op4("t3b", '1, 64'd0, 1'b1);
    op4("t3c", '1, '1, 1'b1);

    // Start while busy is ignored
    @(negedge clk);
    a4 = 64'd5; b4 = 64'd4; c4 = 1'b1; s4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a4 = 64'd7; b4 = 64'd7; c4 = 1'b0; s4 = 1'b1;
    @(posedge clk); #1;
    chk("t4.busy", 65'(busy4), 65'(1));
    chk("t4.hold", {cout4, sum4}, last4);
    @(negedge clk);
    s4 = 1'b0;
    @(posedge clk); #1;
    chk("t4.nodone", 65'(done4), 65'(0));
    @(posedge clk); #1;
    chk("t4.done", 65'(done4), 65'(1));
    chk("t4.result", {cout4, sum4}, 65'd10);
    last4 = 65'd10;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("t4.single_done", 65'({busy4, done4}), 65'(0));
    end

    // Back-to-back with start held high: one capture every 5 cycles
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom);
      a4 = ra; b4 = rb; c4 = rc; s4 = 1'b1;
      if (cyc % 5 == 0) expq.push_back(ref64(ra, rb, rc));
      @(posedge clk); #1;
      if (cyc % 5 == 4) begin
        e = expq.pop_front();
        chk("t5.done", 65'(done4), 65'(1));
        chk("t5.result", {cout4, sum4}, e);
        last4 = e;
      end else begin
        chk("t5.nodone", 65'(done4), 65'(0));
      end
    end
    @(negedge clk);
    s4 = 1'b0;
    @(posedge clk); #1;
    chk("t5.idle", 65'({busy4, done4}), 65'(0));

    // Reset two cycles into RUN
    @(negedge clk);
    a4 = 64'h1234_5678_9ABC_DEF0; b4 = 64'hFFFF_0000_FFFF_0000; c4 = 1'b1; s4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s4 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6.reset", {busy4, done4, cout4, sum4[61:0]}, '0);
    chk("t6.reset_hi", 65'(sum4[63:62]), 65'(0));
    last4 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("t6.nodone", 65'({busy4, done4}), 65'(0));
    end
    op4("t6.after", 64'd1, 64'd2, 1'b0);

    // Random operands on the 4-word instance
    for (int i = 0; i < 6; i++) begin
      op4("rand4", {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
    end

    // Single-word instance
    op1("w1.t1", 16'd1, 16'd2, 1'b0);
    op1("w1.t2", 16'hFFFF, 16'd1, 1'b0);
    op1("w1.t3a", 16'hFFFF, 16'hFFFF, 1'b0);
    op1("w1.t3b", 16'hFFFF, 16'd0, 1'b1);
    op1("w1.t3c", 16'hFFFF, 16'hFFFF, 1'b1);
    for (int i = 0; i < 6; i++) begin
      op1("rand1", 16'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
